// File: rtl/prog_ctr_stack.sv
// prog_ctr_stack
//   Fetch-stage program counter with a hardware return-address stack.
//   Each rising edge applies exactly one action, chosen in this priority:
//     Reset > Stall > Ret > Call > BranchAbs > (BranchRel & Taken) > Start > increment
//   The new PC appears on ProgCtr the cycle after the control edge.
//
// Ports
//   Clk        : clock, all state changes on the rising edge
//   Reset      : synchronous active-high; PC <= RESET_VEC, stack emptied, flags cleared
//   Start      : hold PC when no higher-priority event is present
//   Stall      : freeze PC, stack and flags; every control input except Reset is ignored
//   BranchAbs  : PC <= Target
//   BranchRel  : PC <= PC + signed Target, only when Taken = 1
//   Taken      : branch condition for BranchRel
//   Call       : push PC+1, PC <= Target
//   Ret        : pop the top entry into PC
//   Target     : absolute address or signed relative offset
//   ProgCtr    : program counter register
//   StackDepth : number of valid stack entries, 0..D
//   StackFull  : StackDepth == D
//   StackEmpty : StackDepth == 0
//   Overflow   : sticky, Call executed while full
//   Underflow  : sticky, Ret executed while empty
module prog_ctr_stack #(
    parameter int           L         = 10,
    parameter int           D         = 4,
    parameter logic [L-1:0] RESET_VEC = {L{1'b0}}
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Stall,
    input  logic                   BranchAbs,
    input  logic                   BranchRel,
    input  logic                   Taken,
    input  logic                   Call,
    input  logic                   Ret,
    input  logic [L-1:0]           Target,
    output logic [L-1:0]           ProgCtr,
    output logic [$clog2(D+1)-1:0] StackDepth,
    output logic                   StackFull,
    output logic                   StackEmpty,
    output logic                   Overflow,
    output logic                   Underflow
);

    localparam int DW = $clog2(D + 1);
    localparam int PW = $clog2(D);

    localparam logic [L-1:0]  PC_ONE     = {{(L-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DEPTH_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DEPTH_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] DEPTH_FULL = DW'(D);
    localparam logic [PW-1:0] PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};

    logic [L-1:0]  pc_r;
    logic [DW-1:0] depth_r;
    logic [PW-1:0] top_r;
    logic          ovf_r;
    logic          unf_r;
    logic [L-1:0]  stack_r [D];

    logic [L-1:0]  pc_n_s;
    logic [DW-1:0] depth_n_s;
    logic [PW-1:0] top_n_s;
    logic          ovf_n_s;
    logic          unf_n_s;
    logic          push_s;
    logic [L-1:0]  pc_inc_s;
    logic          full_s;
    logic          empty_s;

    assign pc_inc_s = pc_r + PC_ONE;
    assign full_s   = (depth_r == DEPTH_FULL);
    assign empty_s  = (depth_r == DEPTH_ZERO);

    // Next-state selection following the per-edge priority order (Reset is applied in the register).
    always_comb begin
        pc_n_s    = pc_r;
        depth_n_s = depth_r;
        top_n_s   = top_r;
        ovf_n_s   = ovf_r;
        unf_n_s   = unf_r;
        push_s    = 1'b0;
        if (Stall) begin
            pc_n_s = pc_r;
        end else if (Ret) begin
            // Ret wins over a simultaneous Call; the Call is dropped without a flag.
            if (empty_s) begin
                pc_n_s  = pc_inc_s;
                unf_n_s = 1'b1;
            end else begin
                pc_n_s    = stack_r[top_r];
                depth_n_s = depth_r - DEPTH_ONE;
                top_n_s   = top_r - PTR_ONE;
            end
        end else if (Call) begin
            // The pointer always advances mod D, so a push while full lands on
            // the oldest entry and the newest return address stays on top.
            pc_n_s  = Target;
            top_n_s = top_r + PTR_ONE;
            push_s  = 1'b1;
            if (full_s) begin
                ovf_n_s = 1'b1;
            end else begin
                depth_n_s = depth_r + DEPTH_ONE;
            end
        end else if (BranchAbs) begin
            pc_n_s = Target;
        end else if (BranchRel && Taken) begin
            // Target is already L bits wide, so an L-bit add is the signed add mod 2^L.
            pc_n_s = pc_r + Target;
        end else if (Start) begin
            pc_n_s = pc_r;
        end else begin
            pc_n_s = pc_inc_s;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r    <= RESET_VEC;
            depth_r <= DEPTH_ZERO;
            top_r   <= PTR_ZERO;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            pc_r    <= pc_n_s;
            depth_r <= depth_n_s;
            top_r   <= top_n_s;
            ovf_r   <= ovf_n_s;
            unf_r   <= unf_n_s;
        end
    end

    // Return-address storage; contents are don't-care after reset, so no reset branch.
    always_ff @(posedge Clk) begin
        if (push_s && !Reset) begin
            stack_r[top_n_s] <= pc_inc_s;
        end
    end

    assign ProgCtr    = pc_r;
    assign StackDepth = depth_r;
    assign StackFull  = full_s;
    assign StackEmpty = empty_s;
    assign Overflow   = ovf_r;
    assign Underflow  = unf_r;

endmodule

// File: tb/tb_prog_ctr_stack.sv
// Directed bench for prog_ctr_stack (L=10, D=4, RESET_VEC=0x010).
// The driver applies one control vector per cycle and queues the hand-computed
// state expected after that edge; the monitor pops and compares after each edge.
module tb_prog_ctr_stack;

    localparam logic [7:0] C_NONE  = 8'h00;
    localparam logic [7:0] C_RET   = 8'h01;
    localparam logic [7:0] C_CALL  = 8'h02;
    localparam logic [7:0] C_TAKEN = 8'h04;
    localparam logic [7:0] C_BREL  = 8'h08;
    localparam logic [7:0] C_BABS  = 8'h10;
    localparam logic [7:0] C_START = 8'h20;
    localparam logic [7:0] C_STALL = 8'h40;
    localparam logic [7:0] C_RESET = 8'h80;

    typedef struct {
        logic [9:0] pc;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       Clk;
    logic       Reset, Start, Stall, BranchAbs, BranchRel, Taken, Call, Ret;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic [2:0] StackDepth;
    logic       StackFull, StackEmpty, Overflow, Underflow;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    prog_ctr_stack #(.L(10), .D(4), .RESET_VEC(10'h010)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Taken(Taken),
        .Call(Call), .Ret(Ret), .Target(Target),
        .ProgCtr(ProgCtr), .StackDepth(StackDepth), .StackFull(StackFull),
        .StackEmpty(StackEmpty), .Overflow(Overflow), .Underflow(Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, req);
        end
    endtask

    // Drive one control vector before the edge and queue the state expected after it.
    task automatic step(input logic [7:0] ctl, input logic [9:0] tgt,
                        input logic [9:0] epc, input logic [2:0] edep,
                        input logic eo, input logic eu);
        exp_t e;
        @(negedge Clk);
        {Reset, Stall, Start, BranchAbs, BranchRel, Taken, Call, Ret} = ctl;
        Target  = tgt;
        e.pc    = epc;
        e.depth = edep;
        e.ovf   = eo;
        e.unf   = eu;
        exp_q.push_back(e);
        @(posedge Clk);
    endtask

    // Monitor: one expected record per edge, compared just after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_step++;
                chk("pc",        n_step, 32'(ProgCtr),    32'(e.pc));
                chk("depth",     n_step, 32'(StackDepth), 32'(e.depth));
                chk("full",      n_step, 32'(StackFull),  32'(e.depth == 3'd4));
                chk("empty",     n_step, 32'(StackEmpty), 32'(e.depth == 3'd0));
                chk("overflow",  n_step, 32'(Overflow),   32'(e.ovf));
                chk("underflow", n_step, 32'(Underflow),  32'(e.unf));
            end
        end
    end

    initial begin
        int waited;
        {Reset, Stall, Start, BranchAbs, BranchRel, Taken, Call, Ret} = C_NONE;
        Target = 10'h000;

        // reset and free running
        step(C_RESET, 10'h000, 10'h010, 3'd0, 1'b0, 1'b0);
        step(C_NONE,  10'h000, 10'h011, 3'd0, 1'b0, 1'b0);
        step(C_NONE,  10'h000, 10'h012, 3'd0, 1'b0, 1'b0);
        step(C_NONE,  10'h000, 10'h013, 3'd0, 1'b0, 1'b0);
        step(C_START, 10'h000, 10'h013, 3'd0, 1'b0, 1'b0);
        // branches
        step(C_BABS,           10'h020, 10'h020, 3'd0, 1'b0, 1'b0);
        step(C_BREL | C_TAKEN, 10'h3FE, 10'h01E, 3'd0, 1'b0, 1'b0);
        step(C_BABS,           10'h020, 10'h020, 3'd0, 1'b0, 1'b0);
        step(C_BREL,           10'h3FE, 10'h021, 3'd0, 1'b0, 1'b0);
        step(C_BREL | C_START, 10'h3FE, 10'h021, 3'd0, 1'b0, 1'b0);
        step(C_BABS,           10'h3FF, 10'h3FF, 3'd0, 1'b0, 1'b0);
        step(C_NONE,           10'h000, 10'h000, 3'd0, 1'b0, 1'b0);
        step(C_BREL | C_TAKEN, 10'h005, 10'h005, 3'd0, 1'b0, 1'b0);
        // nested call/return
        step(C_BABS, 10'h100, 10'h100, 3'd0, 1'b0, 1'b0);
        step(C_CALL | C_BABS, 10'h200, 10'h200, 3'd1, 1'b0, 1'b0);
        step(C_CALL, 10'h300, 10'h300, 3'd2, 1'b0, 1'b0);
        step(C_RET | C_BABS, 10'h155, 10'h201, 3'd1, 1'b0, 1'b0);
        step(C_RET,  10'h000, 10'h101, 3'd0, 1'b0, 1'b0);
        // overflow with circular overwrite, then underflow
        step(C_BABS, 10'h010, 10'h010, 3'd0, 1'b0, 1'b0);
        step(C_CALL, 10'h020, 10'h020, 3'd1, 1'b0, 1'b0);
        step(C_CALL, 10'h030, 10'h030, 3'd2, 1'b0, 1'b0);
        step(C_CALL, 10'h040, 10'h040, 3'd3, 1'b0, 1'b0);
        step(C_CALL, 10'h050, 10'h050, 3'd4, 1'b0, 1'b0);
        step(C_CALL, 10'h060, 10'h060, 3'd4, 1'b1, 1'b0);
        step(C_RET,  10'h000, 10'h051, 3'd3, 1'b1, 1'b0);
        step(C_RET,  10'h000, 10'h041, 3'd2, 1'b1, 1'b0);
        step(C_RET,  10'h000, 10'h031, 3'd1, 1'b1, 1'b0);
        step(C_RET,  10'h000, 10'h021, 3'd0, 1'b1, 1'b0);
        step(C_RET,  10'h000, 10'h022, 3'd0, 1'b1, 1'b1);
        // stall masking, Call+Ret together
        step(C_CALL, 10'h200, 10'h200, 3'd1, 1'b1, 1'b1);
        step(C_CALL, 10'h300, 10'h300, 3'd2, 1'b1, 1'b1);
        step(C_STALL | C_CALL | C_BABS, 10'h3AA, 10'h300, 3'd2, 1'b1, 1'b1);
        step(C_STALL | C_CALL | C_BABS, 10'h3AA, 10'h300, 3'd2, 1'b1, 1'b1);
        step(C_STALL | C_CALL | C_BABS, 10'h3AA, 10'h300, 3'd2, 1'b1, 1'b1);
        step(C_NONE, 10'h000, 10'h301, 3'd2, 1'b1, 1'b1);
        step(C_CALL | C_RET, 10'h3AA, 10'h201, 3'd1, 1'b1, 1'b1);
        // reset overrides a Call at depth 3 with Overflow set
        step(C_CALL, 10'h250, 10'h250, 3'd2, 1'b1, 1'b1);
        step(C_CALL, 10'h260, 10'h260, 3'd3, 1'b1, 1'b1);
        step(C_RESET | C_CALL, 10'h3AA, 10'h010, 3'd0, 1'b0, 1'b0);
        step(C_NONE, 10'h000, 10'h011, 3'd0, 1'b0, 1'b0);
        // Call+Ret on an empty stack: Ret executes and underflows
        step(C_CALL | C_RET, 10'h3AA, 10'h012, 3'd0, 1'b0, 1'b1);

        @(negedge Clk);
        {Reset, Stall, Start, BranchAbs, BranchRel, Taken, Call, Ret} = C_START;
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge Clk);
            waited++;
        end
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_ctr_stack.md
Name: prog_ctr_stack

Overview:
Parametrised next-generation program counter for the CSE141L processor. It adds a hardware return-address stack for Call/Ret, conditional signed relative branches, stall and programmable reset vector on top of the basic clear/increment/jump behaviour. It sits in the fetch stage and drives the instruction ROM address. Control inputs come from the decoder/branch logic in the same cycle.

Parameters:
L, 10, PC width in bits; equals instruction ROM address width.
D, 4, return-stack depth in entries; D >= 2, power of two.
RESET_VEC, 0, PC value loaded on Reset; L bits wide.

Ports:
Clk  input  1  clock; all state changes on posedge only.
Reset  input  1  synchronous, active-high; forces PC to RESET_VEC and empties the stack.
Start  input  1  hold: while high and no higher-priority event, PC holds its value.
Stall  input  1  pipeline stall; freezes PC and stack and masks all control inputs except Reset.
BranchAbs  input  1  unconditional absolute jump to Target.
BranchRel  input  1  relative branch request; taken only if Taken=1.
Taken  input  1  branch condition from ALU flags.
Call  input  1  push PC+1 and jump to Target (absolute).
Ret  input  1  pop the return address into PC.
Target  input  L  absolute address, or signed two's-complement offset for BranchRel.
ProgCtr  output  L  program counter register.
StackDepth  output  $clog2(D+1)  number of valid stack entries, 0..D.
StackFull  output  1  StackDepth == D (combinational from state).
StackEmpty  output  1  StackDepth == 0 (combinational from state).
Overflow  output  1  sticky; set when Call is executed while full.
Underflow  output  1  sticky; set when Ret is executed while empty.

Behaviour:
- Single clock Clk. Reset is synchronous, active-high; there is no asynchronous reset.
- Reset: ProgCtr=RESET_VEC, StackDepth=0, Overflow=0, Underflow=0. Stack RAM contents are don't-care. Reset overrides everything, including a Call or Ret in flight.
- Per-edge priority (first match wins): Reset > Stall > Ret > Call > BranchAbs > (BranchRel & Taken) > Start > increment.
- Stall: all state holds. Control inputs are ignored and are not queued.
- Ret, not empty: ProgCtr <= top entry; StackDepth -= 1.
- Ret, empty: ProgCtr <= ProgCtr+1; Underflow <= 1; StackDepth stays 0.
- Call, not full: push ProgCtr+1 (mod 2^L); ProgCtr <= Target; StackDepth += 1.
- Call, full: circular overwrite of the oldest entry; the new entry becomes top; ProgCtr <= Target; StackDepth stays D; Overflow <= 1. A later run of D Rets returns the D most recent addresses.
- Call and Ret in the same cycle: Ret executes and Call is ignored; no error flag is set.
- BranchAbs: ProgCtr <= Target.
- BranchRel with Taken=1: ProgCtr <= ProgCtr + sign-extended Target, modulo 2^L.
- BranchRel with Taken=0: treated as absent; falls through to the Start/increment rules.
- Start=1 with no higher event: ProgCtr holds.
- Default: ProgCtr <= ProgCtr+1. Increment wraps 2^L-1 -> 0 with no flag.
- Latency: the new PC is visible on ProgCtr the cycle after the control edge; there are no bubbles inside the block.
- Stack implementation: a D-entry register array with a top pointer, width $clog2(D), wrapping mod D. Top entry reads are registered-state only; there is no combinational path from Target to ProgCtr.
- Overflow and Underflow clear only on Reset.

Test Plan:
- Reset with RESET_VEC=0x010, then 3 free cycles (Start=0) -> ProgCtr 0x010, 0x011, 0x012, 0x013; StackEmpty=1.
- At PC=0x020 apply BranchRel, Taken=1, Target=0x3FE (-2, L=10) -> PC=0x01E; same stimulus with Taken=0 -> PC=0x021. At PC=0x3FF free-running -> PC=0x000, no flag.
- Nested calls: at PC=0x100 Call Target=0x200, at 0x200 Call Target=0x300, then Ret, Ret -> PC sequence 0x200, 0x300, 0x201, 0x101; StackDepth 1, 2, 1, 0.
- D=4: five Calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> Overflow=1, StackFull=1; four Rets -> PCs 0x51, 0x41, 0x31, 0x21; a fifth Ret -> Underflow=1, PC increments.
- Stall=1 held 3 cycles with Call=1 and BranchAbs=1 asserted -> PC and StackDepth unchanged; Call+Ret together with depth 2 -> pop only, depth 1.
- Reset asserted in the same cycle as Call with depth 3 and Overflow=1 -> PC=RESET_VEC, depth 0, flags 0.
